audio_tone_gen: RTL and testbench

- Downstream consumer of the processor's audio control outputs (audioVol, audioSel, audioEn).
- Converts them into a glitch-free square-wave tone with volume-controlled PWM, suitable for a 1-bit audio pin.
- Sits beside the VGA/sprite outputs in the top level, fed directly by the mips core's audio register bits.
- Provides a linear release (fade-out) when audio is disabled.

---
 rtl/audio_tone_gen.sv | 144 ++++++++++++++
 tb/tb_audio_tone_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_tone_gen.sv
// Square-wave tone generator with PWM volume and a linear release fade.
// Driven by the core's audio register bits; audio_pwm feeds a 1-bit audio pin.
module audio_tone_gen #(
  parameter int unsigned BASE_HALF   = 47778,
  parameter int unsigned STEP_HALF   = 2000,
  parameter int unsigned RELEASE_DIV = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] audioVol,
  input  logic [3:0] audioSel,
  input  logic       audioEn,
  output logic       audio_pwm,
  output logic [4:0] audio_level,
  output logic       audio_busy
);

  localparam int unsigned RelW = $clog2(RELEASE_DIV) + 1;

  localparam logic [15:0]     BaseHalf16 = 16'(BASE_HALF);
  localparam logic [15:0]     StepHalf16 = 16'(STEP_HALF);
  localparam logic [RelW-1:0] RelLast    = RelW'(RELEASE_DIV - 1);
  localparam logic [3:0]      SelRest    = 4'd15;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StPlay    = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [3:0]      sel_lat_q, sel_lat_d;
  logic [4:0]      cur_vol_q, cur_vol_d;
  logic            phase_q, phase_d;
  logic [15:0]     tone_cnt_q, tone_cnt_d;
  logic [RelW-1:0] rel_cnt_q, rel_cnt_d;
  logic [4:0]      pwm_cnt_q, pwm_cnt_d;
  logic            audio_pwm_q, audio_pwm_d;
  logic            sounding;

  function automatic logic [15:0] half_of(input logic [3:0] s);
    logic [15:0] prod;
    prod = {12'd0, s} * StepHalf16;
    if (s == SelRest) begin
      return BaseHalf16;
    end
    return BaseHalf16 - prod;
  endfunction

  always_comb begin
    state_d    = state_q;
    sel_lat_d  = sel_lat_q;
    cur_vol_d  = cur_vol_q;
    phase_d    = phase_q;
    tone_cnt_d = tone_cnt_q;
    rel_cnt_d  = rel_cnt_q;

    case (state_q)
      StIdle: begin
        if (audioEn) begin
          state_d    = StPlay;
          sel_lat_d  = audioSel;
          cur_vol_d  = audioVol;
          tone_cnt_d = half_of(audioSel) - 16'd1;
          phase_d    = (audioSel != SelRest);
        end else begin
          phase_d   = 1'b0;
          cur_vol_d = 5'd0;
        end
      end

      StPlay, StRelease: begin
        // Notes only change at a half-period boundary, so no half-period is ever truncated.
        if (tone_cnt_q == 16'd0) begin
          sel_lat_d  = audioSel;
          tone_cnt_d = half_of(audioSel) - 16'd1;
          phase_d    = (audioSel != SelRest) ? ~phase_q : 1'b0;
        end else begin
          tone_cnt_d = tone_cnt_q - 16'd1;
        end

        if (state_q == StPlay) begin
          if (audioEn) begin
            cur_vol_d = audioVol;
          end else begin
            state_d   = StRelease;
            rel_cnt_d = '0;
          end
        end else if (audioEn) begin
          // Re-enable wins over reaching silence on the same edge.
          state_d   = StPlay;
          cur_vol_d = audioVol;
          rel_cnt_d = '0;
        end else if (cur_vol_q == 5'd0) begin
          state_d = StIdle;
          phase_d = 1'b0;
        end else if (rel_cnt_q == RelLast) begin
          rel_cnt_d = '0;
          cur_vol_d = cur_vol_q - 5'd1;
        end else begin
          rel_cnt_d = rel_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        phase_d = 1'b0;
      end
    endcase
  end

  // A rest never sounds, whatever phase holds.
  assign sounding = phase_q && (sel_lat_q != SelRest);

  always_comb begin
    pwm_cnt_d   = (pwm_cnt_q == 5'd30) ? 5'd0 : pwm_cnt_q + 5'd1;
    audio_pwm_d = sounding && (pwm_cnt_q < cur_vol_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      sel_lat_q   <= 4'd0;
      cur_vol_q   <= 5'd0;
      phase_q     <= 1'b0;
      tone_cnt_q  <= 16'd0;
      rel_cnt_q   <= '0;
      pwm_cnt_q   <= 5'd0;
      audio_pwm_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_lat_q   <= sel_lat_d;
      cur_vol_q   <= cur_vol_d;
      phase_q     <= phase_d;
      tone_cnt_q  <= tone_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      audio_pwm_q <= audio_pwm_d;
    end
  end

  assign audio_pwm   = audio_pwm_q;
  assign audio_level = sounding ? cur_vol_q : 5'd0;
  assign audio_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_audio_tone_gen.sv
// Bench for audio_tone_gen: directed vector table, corner sequences, and a random run,
// all checked every cycle against a behavioural model of tone, fade and PWM.
module tb_audio_tone_gen;

  localparam int unsigned BaseHalf = 20;
  localparam int unsigned StepHalf = 1;
  localparam int unsigned RelDiv   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [4:0] vol;
  logic [3:0] sel;
  logic       pwm;
  logic [4:0] level;
  logic       busy;

  always #5 clk = ~clk;

  audio_tone_gen #(
    .BASE_HALF  (BaseHalf),
    .STEP_HALF  (StepHalf),
    .RELEASE_DIV(RelDiv)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .audioVol   (vol),
    .audioSel   (sel),
    .audioEn    (en),
    .audio_pwm  (pwm),
    .audio_level(level),
    .audio_busy (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: m_left is cycles left in the current half-period, release volume is
  // derived from the volume at release start and the cycles spent releasing.
  bit m_busy, m_rel, m_phase, m_pwm;
  int m_vol, m_start, m_age, m_left, m_tick;

  typedef struct {
    bit         rst;
    bit         en;
    logic [4:0] vol;
    logic [3:0] sel;
    int         cycles;
    logic [4:0] lvl;
    bit         busy;
    bit         chk_pwm;
    bit         pwm;
  } vec_t;

  vec_t vecs[20];

  function automatic int half_len(input int s);
    return (s == 15) ? BaseHalf : BaseHalf - s * StepHalf;
  endfunction

  function automatic int model_vol();
    if (!m_busy) return 0;
    if (m_rel) return m_start - m_age / RelDiv;
    return m_vol;
  endfunction

  task automatic model_edge();
    int cv;
    cv = model_vol();
    if (rst) begin
      m_busy = 0; m_rel = 0; m_phase = 0; m_pwm = 0;
      m_vol = 0; m_start = 0; m_age = 0; m_left = 0; m_tick = 0;
      return;
    end
    m_pwm = m_phase && ((m_tick % 31) < cv);
    m_tick++;
    if (!m_busy) begin
      if (en) begin
        m_busy  = 1;
        m_rel   = 0;
        m_vol   = int'(vol);
        m_left  = half_len(int'(sel));
        m_phase = (sel != 4'd15);
      end
    end else begin
      if (m_left == 1) begin
        m_left  = half_len(int'(sel));
        m_phase = (sel != 4'd15) ? !m_phase : 1'b0;
      end else begin
        m_left--;
      end
      if (!m_rel) begin
        if (en) m_vol = int'(vol);
        else begin
          m_rel   = 1;
          m_start = m_vol;
          m_age   = 0;
        end
      end else if (en) begin
        m_rel = 0;
        m_vol = int'(vol);
      end else if (cv == 0) begin
        m_busy  = 0;
        m_phase = 0;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("level", {27'd0, level}, m_phase ? model_vol() : 0);
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("pwm", {31'd0, pwm}, {31'd0, m_pwm});
  endtask

  // Length of the run of high (or low) level cycles, starting from the current one.
  task automatic count_run(input bit want_high, input int start, output int n);
    n = start;
    for (int i = 0; i < 200; i++) begin
      step();
      if ((level != 5'd0) == want_high) n++;
      else break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; vol = 5'd0; sel = 4'd0;

    //           rst en vol sel cyc lvl busy chk pwm
    vecs[0]  = '{1, 1, 31, 0,  3,  0, 0, 1, 0};
    vecs[1]  = '{0, 1, 31, 0,  1, 31, 1, 1, 0};
    vecs[2]  = '{0, 1, 31, 0, 19, 31, 1, 1, 1};
    vecs[3]  = '{0, 1, 31, 0,  1,  0, 1, 1, 1};
    vecs[4]  = '{0, 1, 31, 0,  1,  0, 1, 1, 0};
    vecs[5]  = '{0, 1, 31, 0, 18,  0, 1, 1, 0};
    vecs[6]  = '{0, 1, 31, 0,  1, 31, 1, 1, 0};
    vecs[7]  = '{0, 1,  3, 0,  1,  3, 1, 1, 1};
    vecs[8]  = '{0, 0,  3, 0,  1,  3, 1, 0, 0};
    vecs[9]  = '{0, 0,  3, 0,  3,  3, 1, 0, 0};
    vecs[10] = '{0, 0,  3, 0,  1,  2, 1, 0, 0};
    vecs[11] = '{0, 0,  3, 0,  4,  1, 1, 0, 0};
    vecs[12] = '{0, 0,  3, 0,  4,  0, 1, 0, 0};
    vecs[13] = '{0, 0,  3, 0,  1,  0, 0, 1, 0};
    vecs[14] = '{0, 0,  3, 0,  3,  0, 0, 1, 0};
    vecs[15] = '{0, 1,  3, 0,  1,  3, 1, 0, 0};
    vecs[16] = '{0, 0,  3, 0,  1,  3, 1, 0, 0};
    vecs[17] = '{0, 0,  3, 0,  4,  2, 1, 0, 0};
    vecs[18] = '{0, 1,  3, 0,  1,  3, 1, 0, 0};
    vecs[19] = '{0, 1,  3, 0, 14,  0, 1, 0, 0};

    foreach (vecs[i]) begin
      rst = vecs[i].rst; en = vecs[i].en; vol = vecs[i].vol; sel = vecs[i].sel;
      repeat (vecs[i].cycles) step();
      check($sformatf("vec%0d_level", i), {27'd0, level}, {27'd0, vecs[i].lvl});
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
      if (vecs[i].chk_pwm) check($sformatf("vec%0d_pwm", i), {31'd0, pwm}, {31'd0, vecs[i].pwm});
    end

    // Note change mid high phase: current half completes, then short halves follow.
    rst = 1'b1; step(); step();
    rst = 1'b0; en = 1'b1; sel = 4'd0; vol = 5'd31;
    step();
    repeat (4) step();
    sel = 4'd14;
    count_run(1'b1, 5, n);
    check("note_change_high", n, 20);
    count_run(1'b0, 1, n);
    check("sel14_low", n, 6);
    count_run(1'b1, 1, n);
    check("sel14_high", n, 6);

    // Rest then leave rest: low half of 6 plus a 20-cycle rest, then an 18-cycle high.
    sel = 4'd15;
    repeat (10) step();
    check("rest_busy", {31'd0, busy}, 1);
    check("rest_level", {27'd0, level}, 0);
    sel = 4'd2;
    count_run(1'b0, 11, n);
    check("rest_low_run", n, 26);
    count_run(1'b1, 1, n);
    check("sel2_high", n, 18);

    for (int c = 0; c < 5000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 99) == 0) en = ~en;
      if ($urandom_range(0, 29) == 0) vol = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 39) == 0) sel = 4'($urandom_range(0, 15));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
